// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI burst RAM slave: FSM states and wire command codes.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_DATA
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic state_e cmd_to_state(input logic [1:0] c);
    case (c)
      CMD_WR_ADDR: return ST_WR_ADDR;
      CMD_WR_DATA: return ST_WR_DATA;
      CMD_RD_ADDR: return ST_RD_ADDR;
      default:     return ST_RD_DATA;
    endcase
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM with registered read data; addresses >= DEPTH
// drop writes and read back as zero.
module spi_ram_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              in_range;

  assign in_range = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));

  always_comb begin
    rdata_d = '0;
    if (in_range) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    if (we && in_range) mem_q[addr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_slave_burst.sv
// SPI slave in front of an on-chip RAM with burst read/write and address wrap.
// Optional SPI_FRAME_ERR_EN adds a frame_err pulse output.
module spi_ram_slave_burst
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
`ifdef SPI_FRAME_ERR_EN
  output logic frame_err,
`endif
  output logic busy
);

  localparam int W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CW = $clog2(W);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W-2:0]      sh_q, sh_d;
  logic [W-1:0]      tx_q, tx_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              done_q, done_d;

  logic [W-1:0]      word;
  logic              last;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(DEPTH-1)) return '0;
    return a + 1'b1;
  endfunction

  assign word     = {sh_q, MOSI};
  assign last     = (cnt_q == CW'(W-1));
  assign mem_addr = (state_q == ST_WR_DATA) ? wr_addr_q : rd_addr_q;
  assign mem_we   = (state_q == ST_WR_DATA) && !SS_n && last;

  spi_ram_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (word[DATA_W-1:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    tx_d      = '0;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    done_d    = done_q;
    if (SS_n) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
        ST_CMD: begin
          sh_d = word[W-2:0];
          if (cnt_q == '0) begin
            cnt_d = CW'(1);
          end else begin
            cnt_d   = '0;
            state_d = cmd_to_state({sh_q[0], MOSI});
          end
        end
        ST_WR_ADDR, ST_RD_ADDR: begin
          // Bits beyond the first W-bit group are ignored until SS_n rises.
          if (!done_q) begin
            sh_d = word[W-2:0];
            if (last) begin
              cnt_d  = '0;
              done_d = 1'b1;
              if (state_q == ST_WR_ADDR) wr_addr_d = word[ADDR_W-1:0];
              else                       rd_addr_d = word[ADDR_W-1:0];
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_WR_DATA: begin
          sh_d = word[W-2:0];
          if (last) begin
            cnt_d     = '0;
            wr_addr_d = next_addr(wr_addr_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RD_DATA: begin
          // cnt 0 loads the prefetched word; the RAM then reads rd_addr+1.
          if (cnt_q == '0) begin
            tx_d      = W'(mem_rdata);
            rd_addr_d = next_addr(rd_addr_q);
            cnt_d     = CW'(1);
          end else begin
            tx_d  = {tx_q[W-2:0], 1'b0};
            cnt_d = last ? '0 : cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      tx_q      <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      done_q    <= done_d;
    end
  end

  // tx_q is held at zero outside RD_DATA, so MISO needs no state gating.
  assign MISO = tx_q[W-1];
  assign busy = (state_q != ST_IDLE);

`ifdef SPI_FRAME_ERR_EN
  logic frame_err_q, frame_err_d;
  logic addr_ok;

  assign addr_ok = ({1'b0, mem_addr} < (ADDR_W+1)'(DEPTH));

  always_comb begin
    frame_err_d = 1'b0;
    if (SS_n) begin
      frame_err_d = (state_q == ST_CMD) ||
                    (((state_q == ST_WR_ADDR) || (state_q == ST_WR_DATA) ||
                      (state_q == ST_RD_ADDR)) && (cnt_q != '0));
    end else begin
      frame_err_d = !addr_ok && (((state_q == ST_WR_DATA) && last) ||
                                 ((state_q == ST_RD_DATA) && (cnt_q == '0)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_ram_slave_burst.sv
// Self-checking bench: two slave instances (8/8/200 and 10/16/1024) driven by
// SPI frame tasks and compared against an array-based memory/address model.
module tb_spi_ram_slave_burst;
  import spi_ram_pkg::*;

  localparam int DEP_T [2] = '{200, 1024};
  localparam int W_T   [2] = '{8, 16};
  localparam int AW_T  [2] = '{8, 10};
  localparam int DW_T  [2] = '{8, 16};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst  = 1'b1;
  logic ss_n = 1'b1;
  logic mosi = 1'b0;
  int   sel  = 0;

  logic ss_a, ss_b, miso_a, miso_b, busy_a, busy_b, miso_s;
  assign ss_a   = (sel == 0) ? ss_n : 1'b1;
  assign ss_b   = (sel == 1) ? ss_n : 1'b1;
  assign miso_s = (sel == 0) ? miso_a : miso_b;

`ifdef SPI_FRAME_ERR_EN
  logic frame_err_a, frame_err_b;
  int   err_pulses = 0;
  always @(posedge clk) if (frame_err_a) err_pulses++;
`endif

  spi_ram_slave_burst #(.ADDR_W(8), .DATA_W(8), .DEPTH(200)) ua (
    .clk(clk), .rst(rst), .SS_n(ss_a), .MOSI(mosi), .MISO(miso_a),
`ifdef SPI_FRAME_ERR_EN
    .frame_err(frame_err_a),
`endif
    .busy(busy_a)
  );

  spi_ram_slave_burst #(.ADDR_W(10), .DATA_W(16), .DEPTH(1024)) ub (
    .clk(clk), .rst(rst), .SS_n(ss_b), .MOSI(mosi), .MISO(miso_b),
`ifdef SPI_FRAME_ERR_EN
    .frame_err(frame_err_b),
`endif
    .busy(busy_b)
  );

  // scoreboard / reference model
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] mem_m [2][1024];
  bit          known [2][1024];
  int          m_wr [2] = '{0, 0};
  int          m_rd [2] = '{0, 0};
  logic [15:0] wq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nxt(input int s, input int a);
    if (a == DEP_T[s] - 1) return 0;
    return (a + 1) % (1 << AW_T[s]);
  endfunction

  // driver tasks
  task automatic bit_t(input logic b, output logic m);
    @(negedge clk);
    ss_n = 1'b0;
    mosi = b;
    @(posedge clk);
    #1;
    m = miso_s;
  endtask

  task automatic end_frame();
    @(negedge clk);
    ss_n = 1'b1;
    mosi = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [1:0] c);
    logic m;
    bit_t(1'($urandom_range(0, 1)), m);
    bit_t(c[1], m);
    bit_t(c[0], m);
  endtask

  task automatic send_word(input logic [15:0] v, input int nbits);
    logic m;
    for (int i = W_T[sel] - 1; i >= W_T[sel] - nbits; i--) bit_t(v[i], m);
  endtask

  task automatic set_addr(input bit rd, input logic [15:0] v);
    logic m;
    start_cmd(rd ? CMD_RD_ADDR : CMD_WR_ADDR);
    send_word(v, W_T[sel]);
    bit_t(1'($urandom_range(0, 1)), m);
    bit_t(1'($urandom_range(0, 1)), m);
    end_frame();
    if (rd) m_rd[sel] = int'(v) % (1 << AW_T[sel]);
    else    m_wr[sel] = int'(v) % (1 << AW_T[sel]);
  endtask

  task automatic write_burst();
    start_cmd(CMD_WR_DATA);
    foreach (wq[k]) begin
      send_word(wq[k], W_T[sel]);
      if (m_wr[sel] < DEP_T[sel]) begin
        mem_m[sel][m_wr[sel]] = wq[k] & 16'((1 << DW_T[sel]) - 1);
        known[sel][m_wr[sel]] = 1'b1;
      end
      m_wr[sel] = nxt(sel, m_wr[sel]);
    end
    end_frame();
  endtask

  task automatic read_burst(input int n, input string tag);
    logic        m;
    logic [15:0] got, exp;
    start_cmd(CMD_RD_DATA);
    for (int k = 0; k < n; k++) begin
      got = '0;
      for (int i = W_T[sel] - 1; i >= 0; i--) begin
        bit_t(1'($urandom_range(0, 1)), m);
        got[i] = m;
      end
      exp = (m_rd[sel] < DEP_T[sel]) ? mem_m[sel][m_rd[sel]] : 16'h0;
      if (m_rd[sel] >= DEP_T[sel] || known[sel][m_rd[sel]])
        check($sformatf("%s[%0d]@%0h", tag, k, m_rd[sel]), 32'(got), 32'(exp));
      m_rd[sel] = nxt(sel, m_rd[sel]);
    end
    end_frame();
  endtask

  task automatic check_regs_a(input string tag);
    check({tag, "_wr"}, 32'(ua.wr_addr_q), 32'(m_wr[0]));
    check({tag, "_rd"}, 32'(ua.rd_addr_q), 32'(m_rd[0]));
  endtask

  initial begin
    logic m;
    int   a, n;

    // reset with SS_n toggling
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ss_n = i[0];
      mosi = 1'b1;
    end
    @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_miso", 32'(miso_a), 32'd0);
    check("rst_state", 32'(ua.state_q), 32'(ST_IDLE));
    check_regs_a("rst");
    check("rst_b_busy", 32'(busy_b), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    ss_n = 1'b1;
    @(posedge clk);
    #1;

    // fill instance A so every readback has a known expectation
    sel = 0;
    set_addr(1'b0, 16'h0);
    wq.delete();
    for (int i = 0; i < 200; i++) wq.push_back(16'($urandom_range(0, 255)));
    write_burst();
    check_regs_a("fill");

    // directed burst write / read
    set_addr(1'b0, 16'h3C);
    wq.delete();
    wq.push_back(16'hA5); wq.push_back(16'h5A); wq.push_back(16'hFF);
    write_burst();
    check("burst_wr_addr", 32'(ua.wr_addr_q), 32'h3F);
    set_addr(1'b1, 16'h3C);
    read_burst(3, "burst_rd");
    check("burst_rd_addr", 32'(ua.rd_addr_q), 32'h3F);

    // wrap at DEPTH-1
    set_addr(1'b0, 16'd199);
    wq.delete();
    wq.push_back(16'h11); wq.push_back(16'h22);
    write_burst();
    check("wrap_wr_addr", 32'(ua.wr_addr_q), 32'd1);
    set_addr(1'b1, 16'd199);
    read_burst(2, "wrap_rd");

    // abort WR_ADDR after 5 of 8 payload bits
    set_addr(1'b0, 16'h10);
`ifdef SPI_FRAME_ERR_EN
    n = err_pulses;
`endif
    start_cmd(CMD_WR_ADDR);
    check("frame_busy", 32'(busy_a), 32'd1);
    send_word(16'h77, 5);
    end_frame();
    check("abort_state", 32'(ua.state_q), 32'(ST_IDLE));
    check("abort_busy", 32'(busy_a), 32'd0);
    check_regs_a("abort");
    @(posedge clk);
    #1;
`ifdef SPI_FRAME_ERR_EN
    check("abort_err", 32'(err_pulses - n), 32'd1);
`endif

    // SS_n rises on the edge that would sample the last data bit
    start_cmd(CMD_WR_DATA);
    send_word(16'h00, 7);
    end_frame();
    check_regs_a("lastbit_abort");
    set_addr(1'b1, 16'h10);
    read_burst(1, "lastbit_rd");

    // out-of-range: writes dropped, reads zero, 2**ADDR_W rollover
    set_addr(1'b0, 16'd230);
    wq.delete();
    wq.push_back(16'hC3);
    write_burst();
    check_regs_a("oor_wr");
    set_addr(1'b1, 16'd250);
    read_burst(2, "oor_rd");
    set_addr(1'b1, 16'd255);
    read_burst(2, "roll_rd");

    // randomized bursts
    for (int it = 0; it < 20; it++) begin
      set_addr(1'b0, 16'($urandom_range(0, 255)));
      wq.delete();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) wq.push_back(16'($urandom_range(0, 255)));
      write_burst();
      a = $urandom_range(0, 3) == 0 ? $urandom_range(190, 255) : $urandom_range(0, 199);
      set_addr(1'b1, 16'(a));
      read_burst($urandom_range(1, 4), "rand_rd");
    end
    check_regs_a("rand_end");

    // reset in the middle of a read frame
    set_addr(1'b1, 16'h3C);
    start_cmd(CMD_RD_DATA);
    for (int i = 0; i < 3; i++) bit_t(1'b0, m);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_wr = '{0, 0};
    m_rd = '{0, 0};
    check("mid_rst_state", 32'(ua.state_q), 32'(ST_IDLE));
    check("mid_rst_miso", 32'(miso_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check_regs_a("mid_rst");
    @(negedge clk);
    rst  = 1'b0;
    ss_n = 1'b1;
    @(posedge clk);
    #1;
    read_burst(2, "post_rst_rd");

    // wide instance: 10-bit address, 16-bit data
    sel = 1;
    set_addr(1'b0, 16'hFC00 | 16'h3FF);
    wq.delete();
    wq.push_back(16'hBEEF);
    write_burst();
    check("wide_wr_addr", 32'(ub.wr_addr_q), 32'd0);
    set_addr(1'b1, 16'h3FF);
    read_burst(1, "wide_rd");
    for (int it = 0; it < 4; it++) begin
      a = $urandom_range(0, 1023);
      set_addr(1'b0, 16'(a));
      wq.delete();
      for (int k = 0; k < 3; k++) wq.push_back(16'($urandom));
      write_burst();
      set_addr(1'b1, 16'(a));
      read_burst(3, "wide_rand_rd");
    end
    check("wide_rd_addr", 32'(ub.rd_addr_q), 32'(m_rd[1]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
